// File: rtl/gpio_bus_arbiter.sv
// gpio_bus_arbiter: round-robin sharing of one Wishbone GPIO slave among NUM_M masters, one transaction per grant.
// Define GPIO_ARB_TIMEOUT_EN to add a BUSY watchdog that errors out transactions the slave never terminates.
module gpio_bus_arbiter #(
  parameter int NUM_M       = 4,
  parameter int Dw          = 32,
  parameter int Aw          = 2,
  parameter int SELw        = 4,
  parameter int TAGw        = 3,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_M*Dw-1:0]    m_dat_i,
  input  logic [NUM_M*SELw-1:0]  m_sel_i,
  input  logic [NUM_M*Aw-1:0]    m_addr_i,
  input  logic [NUM_M*TAGw-1:0]  m_tag_i,
  input  logic [NUM_M-1:0]       m_stb_i,
  input  logic [NUM_M-1:0]       m_cyc_i,
  input  logic [NUM_M-1:0]       m_we_i,
  output logic [Dw-1:0]          m_dat_o,
  output logic [NUM_M-1:0]       m_ack_o,
  output logic [NUM_M-1:0]       m_err_o,
  output logic [NUM_M-1:0]       m_rty_o,
  output logic [Dw-1:0]          s_dat_o,
  output logic [SELw-1:0]        s_sel_o,
  output logic [Aw-1:0]          s_addr_o,
  output logic [TAGw-1:0]        s_tag_o,
  output logic                   s_stb_o,
  output logic                   s_cyc_o,
  output logic                   s_we_o,
  input  logic [Dw-1:0]          s_dat_i,
  input  logic                   s_ack_i,
  input  logic                   s_err_i,
  input  logic                   s_rty_i,
  output logic [NUM_M-1:0]       grant_o
);
  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t           state_q, state_d;
  logic [NUM_M-1:0] grant_q, grant_d, req, pick;
  logic [IW-1:0]    last_q, last_d, g;
  logic             term, expire, gcyc, found;
  if (NUM_M < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("gpio_bus_arbiter: NUM_M and TIMEOUT_CYC must be >= 1");
  end
  assign req     = m_cyc_i & m_stb_i;
  assign term    = s_ack_i | s_err_i | s_rty_i;
  assign gcyc    = |(m_cyc_i & grant_q);
  assign grant_o = grant_q;
  assign m_dat_o = s_dat_i;
`ifdef GPIO_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // Counter sits at 0 in IDLE, so the first BUSY cycle sees 0 and expiry lands on the TIMEOUT_CYC-th BUSY cycle.
  assign cnt_d  = (state_q == BUSY) ? cnt_q + 1'b1 : '0;
  assign expire = (state_q == BUSY) && (cnt_q == CW'(TIMEOUT_CYC - 1)) && !term;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign expire = 1'b0;
`endif
  always_comb begin
    g = '0;
    for (int i = 0; i < NUM_M; i++) if (grant_q[i]) g = IW'(i);
  end
  // Search masters after the last one served first, then wrap around to the rest.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_M; k++) if (!found && req[k] && k > int'(last_q)) begin
      pick[k] = 1'b1;
      found   = 1'b1;
    end
    for (int k = 0; k < NUM_M; k++) if (!found && req[k] && k <= int'(last_q)) begin
      pick[k] = 1'b1;
      found   = 1'b1;
    end
  end
  // grant_q is non-zero only in BUSY, so the AND-OR mux yields IDLE zeros for free.
  always_comb begin
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_addr_o = '0;
    s_tag_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m_ack_o  = '0;
    m_err_o  = '0;
    m_rty_o  = '0;
    for (int i = 0; i < NUM_M; i++) if (grant_q[i]) begin
      s_dat_o    = m_dat_i[i*Dw +: Dw];
      s_sel_o    = m_sel_i[i*SELw +: SELw];
      s_addr_o   = m_addr_i[i*Aw +: Aw];
      s_tag_o    = m_tag_i[i*TAGw +: TAGw];
      s_we_o     = m_we_i[i];
      s_cyc_o    = m_cyc_i[i] & ~expire;
      s_stb_o    = m_cyc_i[i] & m_stb_i[i] & ~expire;
      m_ack_o[i] = s_ack_i;
      m_err_o[i] = s_err_i | expire;
      m_rty_o[i] = s_rty_i;
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    if (state_q == IDLE && |req) begin
      state_d = BUSY;
      grant_d = pick;
    end else if (state_q == BUSY && (term || !gcyc || expire)) begin
      state_d = IDLE;
      grant_d = '0;
      last_d  = g;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_M - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// tb_gpio_bus_arbiter: directed and random traffic against a cycle-level model of the round-robin sharing rules.
module tb_gpio_bus_arbiter;
  localparam int N = 4, DW = 32, AW = 2, SW = 4, TW = 3, TO = 8;
`ifdef GPIO_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic [N*DW-1:0] m_dat = '0, nx_dat;
  logic [N*SW-1:0] m_sel = '0, nx_sel;
  logic [N*AW-1:0] m_addr = '0, nx_addr;
  logic [N*TW-1:0] m_tag = '0, nx_tag;
  logic [N-1:0] m_stb = '0, m_cyc = '0, m_we = '0, nx_stb, nx_cyc, nx_we;
  logic [DW-1:0] m_dat_o, s_dat_o, s_dat_i = '0;
  logic [N-1:0] m_ack_o, m_err_o, m_rty_o, grant_o;
  logic [SW-1:0] s_sel_o;
  logic [AW-1:0] s_addr_o;
  logic [TW-1:0] s_tag_o;
  logic s_stb_o, s_cyc_o, s_we_o;
  logic s_ack_i = 1'b0, s_err_i = 1'b0, s_rty_i = 1'b0;
  int checks = 0, errors = 0;
  bit busy_m = 0, rnd = 0, slave_en = 1;
  int g_m = 0, last_m = N - 1, bcnt = 0;
  bit again[N] = '{default: 0};
  logic [N-1:0] prev_obs = '0;
  int gq[$];
  int exp2[5] = '{0, 1, 2, 3, 0};
  int exp3[3] = '{2, 3, 0};

  gpio_bus_arbiter #(.NUM_M(N), .Dw(DW), .Aw(AW), .SELw(SW), .TAGw(TW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .m_dat_i(m_dat), .m_sel_i(m_sel), .m_addr_i(m_addr), .m_tag_i(m_tag),
    .m_stb_i(m_stb), .m_cyc_i(m_cyc), .m_we_i(m_we),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_addr_o(s_addr_o), .s_tag_o(s_tag_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_we_o(s_we_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_txn(input int k, input int we);
    nx_cyc[k] = 1'b1;
    nx_stb[k] = 1'b1;
    nx_we[k] = (we < 0) ? 1'($urandom) : 1'(we);
    nx_dat[k*DW +: DW] = $urandom;
    nx_sel[k*SW +: SW] = SW'($urandom);
    nx_addr[k*AW +: AW] = AW'($urandom);
    nx_tag[k*TW +: TW] = TW'($urandom);
  endtask

  task automatic launch(input int k, input int we);
    nx_dat = m_dat; nx_sel = m_sel; nx_addr = m_addr; nx_tag = m_tag;
    nx_stb = m_stb; nx_cyc = m_cyc; nx_we = m_we;
    new_txn(k, we);
    m_dat = nx_dat; m_sel = nx_sel; m_addr = nx_addr; m_tag = nx_tag;
    m_stb = nx_stb; m_cyc = nx_cyc; m_we = nx_we;
  endtask

  // One clock: check outputs against the model mid-cycle, advance model, slave and masters, apply after the edge.
  task automatic tick();
    logic [N-1:0] eg, req;
    bit term, expire, found, n_ack, n_err, n_rty;
    int r;
    @(negedge clk);
    req = m_cyc & m_stb;
    term = s_ack_i | s_err_i | s_rty_i;
    expire = TO_EN && busy_m && bcnt == TO && !term;
    eg = busy_m ? N'(1 << g_m) : '0;
    chk("grant", grant_o, eg);
    chk("ack", m_ack_o, s_ack_i ? eg : '0);
    chk("err", m_err_o, (s_err_i || expire) ? eg : '0);
    chk("rty", m_rty_o, s_rty_i ? eg : '0);
    chk("m_dat_o", m_dat_o, s_dat_i);
    chk("s_cyc", s_cyc_o, busy_m && m_cyc[g_m] && !expire);
    chk("s_stb", s_stb_o, busy_m && m_cyc[g_m] && m_stb[g_m] && !expire);
    if (busy_m) begin
      chk("s_addr", s_addr_o, m_addr[g_m*AW +: AW]);
      chk("s_dat", s_dat_o, m_dat[g_m*DW +: DW]);
      chk("s_we", s_we_o, m_we[g_m]);
      chk("s_sel", s_sel_o, m_sel[g_m*SW +: SW]);
      chk("s_tag", s_tag_o, m_tag[g_m*TW +: TW]);
    end
    if (grant_o != 0 && prev_obs == 0) for (int k = 0; k < N; k++) if (grant_o[k]) gq.push_back(k);
    prev_obs = grant_o;
    if (busy_m) begin
      if (term || !m_cyc[g_m] || expire) begin
        busy_m = 0;
        last_m = g_m;
      end else bcnt++;
    end else if (req != 0) begin
      found = 0;
      for (int j = 1; j <= N; j++) if (!found && req[(last_m + j) % N]) begin
        g_m = (last_m + j) % N;
        found = 1;
      end
      busy_m = 1;
      bcnt = 1;
    end
    n_ack = 0; n_err = 0; n_rty = 0;
    if (slave_en && s_stb_o && !term) begin
      r = rnd ? int'($urandom_range(0, 5)) : 0;
      n_ack = r < 4; n_err = r == 4; n_rty = r == 5;
    end
    nx_dat = m_dat; nx_sel = m_sel; nx_addr = m_addr; nx_tag = m_tag;
    nx_stb = m_stb; nx_cyc = m_cyc; nx_we = m_we;
    for (int k = 0; k < N; k++) begin
      if (m_ack_o[k] || m_err_o[k] || m_rty_o[k]) begin
        if (again[k]) new_txn(k, -1);
        else begin nx_cyc[k] = 1'b0; nx_stb[k] = 1'b0; end
      end else if (rnd) begin
        if (!m_cyc[k] && $urandom_range(0, 2) == 0) new_txn(k, -1);
        else if (m_cyc[k] && $urandom_range(0, 39) == 0) begin nx_cyc[k] = 1'b0; nx_stb[k] = 1'b0; end
      end
    end
    @(posedge clk);
    #1;
    m_dat = nx_dat; m_sel = nx_sel; m_addr = nx_addr; m_tag = nx_tag;
    m_stb = nx_stb; m_cyc = nx_cyc; m_we = nx_we;
    s_ack_i = n_ack; s_err_i = n_err; s_rty_i = n_rty;
    if (rnd) s_dat_i = $urandom;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_cyc = '0; m_stb = '0;
    s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    again = '{default: 0};
    busy_m = 0; last_m = N - 1; bcnt = 0; prev_obs = '0;
    #1;
    chk("rst_grant", grant_o, '0);
    chk("rst_stb", s_stb_o, 1'b0);
    chk("rst_cyc", s_cyc_o, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    rnd = 0;
    again = '{default: 0};
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      ok = (m_cyc == 0) && (grant_o == 0);
    end
    chk("drain", ok, 1'b1);
  endtask

  initial begin
    int n;
    bit seen;
    do_reset();
    // single write from m0
    launch(0, 1);
    m_addr[AW-1:0] = 2'd1;
    m_dat[DW-1:0] = 32'h5;
    tick(); #1;
    chk("t1_grant", grant_o, 4'b0001);
    chk("t1_we", s_we_o, 1'b1);
    chk("t1_addr", s_addr_o, 2'd1);
    chk("t1_dat", s_dat_o, 32'h5);
    tick(); #1;
    chk("t1_ack", m_ack_o, 4'b0001);
    tick(); #1;
    chk("t1_idle", grant_o, 4'b0000);
    // all masters requesting continuously
    do_reset();
    gq.delete();
    for (int k = 0; k < N; k++) begin again[k] = 1; launch(k, -1); end
    for (int i = 0; i < 60 && gq.size() < 5; i++) tick();
    chk("t2_count", gq.size() >= 5, 1'b1);
    for (int i = 0; i < 5; i++) chk($sformatf("t2_order%0d", i), (gq.size() > i) ? gq[i] : -1, exp2[i]);
    drain();
    // m2 alone, then m0 and m3 together
    gq.delete();
    launch(2, -1);
    repeat (4) tick();
    launch(0, -1);
    launch(3, -1);
    repeat (8) tick();
    chk("t3_count", gq.size(), 3);
    for (int i = 0; i < 3; i++) chk($sformatf("t3_order%0d", i), (gq.size() > i) ? gq[i] : -1, exp3[i]);
    drain();
    // read by m1
    s_dat_i = 32'hA5;
    launch(1, 0);
    tick(); tick(); #1;
    chk("t4_dat", m_dat_o, 32'hA5);
    chk("t4_ack", m_ack_o, 4'b0010);
    chk("t4_err", m_err_o, 4'b0000);
    chk("t4_rty", m_rty_o, 4'b0000);
    drain();
    // random traffic with ack/err/rty responses and aborts
    rnd = 1;
    repeat (400) tick();
    drain();
    // silent slave
    slave_en = 0;
    launch(1, -1);
`ifdef GPIO_ARB_TIMEOUT_EN
    n = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick(); #1;
      if (grant_o != 0) n++;
      if (m_err_o != 0) seen = 1;
    end
    chk("t5_seen", seen, 1'b1);
    chk("t5_cycles", n, TO);
    chk("t5_errbit", m_err_o, 4'b0010);
    chk("t5_stb", s_stb_o, 1'b0);
    tick();
`else
    n = 0; seen = 0;
    repeat (100) tick();
    #1;
    chk("t5_hold", grant_o, 4'b0010);
    m_cyc[1] = 1'b0;
    m_stb[1] = 1'b0;
    tick(); #1;
    chk("t5_abort", grant_o, 4'b0000);
    chk("t5_noerr", m_err_o, 4'b0000);
`endif
    slave_en = 1;
    drain();
    // asynchronous reset during an acked BUSY cycle
    launch(2, -1);
    tick(); tick(); #1;
    chk("t6_pre_ack", m_ack_o, 4'b0100);
    #1 reset = 1'b1;
    #1;
    chk("t6_grant0", grant_o, 4'b0000);
    chk("t6_stb0", s_stb_o, 1'b0);
    chk("t6_ack0", m_ack_o, 4'b0000);
    do_reset();
    launch(1, -1);
    launch(0, -1);
    tick(); #1;
    chk("t6_grant", grant_o, 4'b0001);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
